// File: rtl/trace_pkg.sv
// Shared types and helpers for the commit trace buffer.
package trace_pkg;

  localparam int MAX_LANES   = 2;
  localparam int RD_W        = 5;
  localparam int TRACE_XLEN  = 32;
  localparam int TRACE_SEQ_W = 16;

  // Field order matches the packed entry layout built in the top (pc in the MSBs, seq in the LSBs).
  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_XLEN-1:0]  instr;
    logic [TRACE_XLEN-1:0]  result;
    logic [RD_W-1:0]        rd;
    logic                   regwrite;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  function automatic logic [1:0] lane_count(input logic [MAX_LANES-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular entry store accepting up to LANES pushes and one pop per cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 1,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               push_cnt_i,
  input  logic [LANES*W-1:0]       push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_d    = wr_q + AW'(push_cnt_i);
    rd_d    = rd_q + AW'(pop_i);
    count_d = count_q + CW'(push_cnt_i) - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (!reset && (push_cnt_i > 2'(i)))
        mem[wr_q + AW'(i)] <= push_data_i[i*W +: W];
    end
  end

  assign head_o  = mem[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Multi-lane retire trace capture: never stalls the core, drops on full and accounts for the loss.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LANES  = 1,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0]          ret_valid,
  input  logic [LANES*XLEN-1:0]     ret_pc,
  input  logic [LANES*XLEN-1:0]     ret_instr,
  input  logic [LANES*XLEN-1:0]     ret_result,
  input  logic [LANES*RD_W-1:0]     ret_rd,
  input  logic [LANES-1:0]          ret_regwrite,
  input  logic                      filter_x0,
  input  logic                      clear_ovf,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [XLEN-1:0]           trace_pc,
  output logic [XLEN-1:0]           trace_instr,
  output logic [XLEN-1:0]           trace_result,
  output logic [RD_W-1:0]           trace_rd,
  output logic                      trace_regwrite,
  output logic [SEQ_W-1:0]          trace_seq,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int FW      = AW + 2;
  localparam int ENTRY_W = 3*XLEN + RD_W + 1 + SEQ_W;
  localparam int O_RW    = SEQ_W;
  localparam int O_RD    = SEQ_W + 1;
  localparam int O_RES   = O_RD + RD_W;
  localparam int O_INS   = O_RES + XLEN;
  localparam int O_PC    = O_INS + XLEN;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a, input logic [1:0] b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + (DROP_W+1)'(b);
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic [ENTRY_W-1:0]     lane_entry [LANES];
  logic [LANES*ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0]     head_w;
  logic [AW:0]            fill_w;
  logic [FW-1:0]          free_w;
  logic [1:0]             n_valid, n_acc, n_drop;
  logic                   pop_w;

  // Each valid lane takes the sequence slot of its position among this cycle's valid lanes.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SEQ_W-1:0] seq_l;
    logic [RD_W-1:0]  rd_l;
    if (l == 0) begin : g_first
      assign seq_l = seq_q;
    end else begin : g_later
      assign seq_l = seq_q + SEQ_W'(ret_valid[0]);
    end
    assign rd_l = ret_rd[l*RD_W +: RD_W];
    assign lane_entry[l] = {ret_pc[l*XLEN +: XLEN], ret_instr[l*XLEN +: XLEN],
                            ret_result[l*XLEN +: XLEN], rd_l,
                            ret_regwrite[l] & ~(filter_x0 & (rd_l == '0)), seq_l};
  end

  // Compact valid lanes into slot order so a lone lane 1 lands in slot 0.
  assign push_data[0 +: ENTRY_W] = ret_valid[0] ? lane_entry[0] : lane_entry[LANES-1];
  if (LANES > 1) begin : g_slot1
    assign push_data[ENTRY_W +: ENTRY_W] = lane_entry[1];
  end

  assign n_valid = lane_count(MAX_LANES'(ret_valid));
  assign pop_w   = trace_valid & trace_ready;
  assign free_w  = FW'(DEPTH) - FW'(fill_w) + FW'(pop_w);

  always_comb begin
    n_acc = n_valid;
    if (FW'(n_valid) > free_w) n_acc = free_w[1:0];
  end

  assign n_drop = n_valid - n_acc;

  always_comb begin
    seq_d  = seq_q + SEQ_W'(n_valid);
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (n_drop != 2'd0) begin
      ovf_d  = 1'b1;
      drop_d = clear_ovf ? DROP_W'(n_drop) : sat_add(drop_q, n_drop);
    end else if (clear_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  trace_fifo #(
    .W     (ENTRY_W),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_cnt_i  (n_acc),
    .push_data_i (push_data),
    .pop_i       (pop_w),
    .head_o      (head_w),
    .count_o     (fill_w)
  );

  assign trace_valid    = (fill_w != '0);
  assign trace_pc       = trace_valid ? head_w[O_PC  +: XLEN] : '0;
  assign trace_instr    = trace_valid ? head_w[O_INS +: XLEN] : '0;
  assign trace_result   = trace_valid ? head_w[O_RES +: XLEN] : '0;
  assign trace_rd       = trace_valid ? head_w[O_RD  +: RD_W] : '0;
  assign trace_regwrite = trace_valid & head_w[O_RW];
  assign trace_seq      = trace_valid ? head_w[SEQ_W-1:0] : '0;
  assign fill_level     = fill_w;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised retire-trace capture block between the CPU core's commit stage and the verification environment. It generalises the single-lane, unbuffered monitor signals (pc, instr, result, rd, regwrite) to `LANES` retire ports. Accepted retires go into a `DEPTH`-entry FIFO that the testbench drains through a valid/ready handshake. The core is never stalled: a full buffer drops entries and records the loss through a sequence number, a drop counter and a sticky overflow flag.

## Interface
Parameters:
- `XLEN`, 32, width of pc/instr/result.
- `LANES`, 1, retire lanes per cycle; legal values 1 or 2.
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `SEQ_W`, 16, sequence-number width.
- `DROP_W`, 16, drop-counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ret_valid`  in  LANES  a retire is present on each lane; lane 0 is oldest.
- `ret_pc`, `ret_instr`, `ret_result`  in  LANES×XLEN  per-lane retire data.
- `ret_rd`  in  LANES×5  destination register.
- `ret_regwrite`  in  LANES  register-write flag.
- `filter_x0`  in  1  when high, forces stored regwrite to 0 if rd == 0.
- `clear_ovf`  in  1  clears `overflow` and `drop_count`.
- `trace_valid`  out  1  head entry available.
- `trace_ready`  in  1  testbench consumes head.
- `trace_pc`, `trace_instr`, `trace_result`  out  XLEN  head entry fields.
- `trace_rd`  out  5  head entry rd.
- `trace_regwrite`  out  1  head entry regwrite, after filtering.
- `trace_seq`  out  SEQ_W  head entry sequence number.
- `fill_level`  out  clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set when any retire is dropped.
- `drop_count`  out  DROP_W  saturating count of dropped retires.

## Operation
- Pop occurs when `trace_valid && trace_ready`. Push candidates are the lanes with `ret_valid` set, taken in lane order; lane 1 with lane 0 idle is accepted as a single retire.
- Free space is DEPTH − fill_level + (pop ? 1 : 0), so a pop in the same cycle credits a slot.
- If free space is at least the number of valid lanes, all valid lanes are accepted. Otherwise the oldest lanes are accepted up to the free space and the rest are dropped.
- Sequence numbering: `seq_next` advances by the number of valid lanes, accepted or dropped, and wraps modulo 2^SEQ_W. Each accepted entry stores the sequence value of its own position, so drops show up as gaps.
- Drop accounting: `drop_count` adds the number of dropped lanes and saturates at all-ones. `overflow` sets on any drop.
- `clear_ovf` zeroes `overflow` and `drop_count`. If a drop happens in the same cycle as `clear_ovf`, the drop wins: overflow = 1 and drop_count = the new drops only.
- `filter_x0` is sampled at push, per entry. Flipping it later does not alter stored entries.
- Trace outputs are held stable while `trace_valid && !trace_ready`.

## Timing
- Reset values: fill_level = 0, trace_valid = 0, overflow = 0, drop_count = 0, seq_next = 0. All trace data outputs are 0.
- Reset is synchronous. Asserting it mid-operation discards all contents at that edge, and retires presented in the reset cycle are ignored.
- Latency: a retire sampled at edge N is visible on `trace_*` with `trace_valid` = 1 after edge N. This is one cycle from an empty buffer.
- Throughput: up to LANES pushes and 1 pop per cycle.
- When the buffer is full and a pop occurs with one valid lane, that lane is accepted and fill_level stays at DEPTH.
- Pointers wrap modulo DEPTH. Full means fill_level == DEPTH.

## Structure
- Package `trace_pkg`:
  - `trace_entry_t` struct holding pc, instr, result, rd, regwrite and seq, with parametrised widths via localparams.
  - Constant `MAX_LANES = 2`.
- Sub-module `trace_fifo`: storage with multi-push (≤ LANES) and single-pop, plus pointers and occupancy. Drop, sequence and filter logic stay in the top.

## Test plan
- Reset, then one lane-0 retire with pc = 0x100, rd = 5, regwrite = 1, trace_ready = 1 → next cycle trace_valid = 1, trace_pc = 0x100, trace_seq = 0, then fill_level = 0.
- LANES = 2, both lanes valid with pc 0x10 and 0x14 → popped in order 0x10 then 0x14, with seq 0 then 1.
- DEPTH = 4, trace_ready = 0, six single retires → fill_level = 4, drop_count = 2, overflow = 1. Draining yields seq 0–3 only; the next retire stores seq 6.
- Full buffer, pop plus one retire in the same cycle → no drop, fill_level stays 4, new entry appended.
- filter_x0 = 1, retire with rd = 0 and regwrite = 1 → trace_regwrite = 0. Same stimulus with filter_x0 = 0 → trace_regwrite = 1.
- Reset asserted with 3 entries held and a retire present → after the edge, fill_level = 0, trace_valid = 0, overflow = 0, and the next accepted retire carries seq 0.
